mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Sequencing controller for the team's 2:1 datapath multiplexer (y = s ? d1 : d0, built from 7404/7408/7432 parts).
- Arbitrates two requesters for the shared mux, drives its select line, and emits the muxed data plus one-hot grants.
- Round-robin on tie, hold-while-requested, with a hold limit so neither requester can starve the other.
- Top level maps requests and data to SW and grants, select and y to LEDR.

Parameters:
- W, 1, data width of d0/d1/y.
- MAX_HOLD, 4, max consecutive grant cycles while the other requester waits; legal range 1..255.
- CW, 8, width of grant statistics counters (MUX_ARB_STATS_EN only).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants the mux.
- req1  input  1  requester 1 wants the mux.
- d0  input  W  requester 0 data (mux x input, s=0).
- d1  input  W  requester 1 data (mux y input, s=1).
- gnt0  output  1  registered, requester 0 owns the mux.
- gnt1  output  1  registered, requester 1 owns the mux.
- sel  output  1  registered mux select; 0 selects d0.
- y  output  W  combinational: d0 if gnt0, d1 if gnt1, else 0.
- busy  output  1  gnt0 | gnt1.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of Clock.
- Reset values: state=IDLE, gnt0=0, gnt1=0, sel=0, busy=0, y=0, hold_cnt=0, last=1 (requester 0 wins the first tie).
- Reset mid-grant drops both grants on the next edge; no partial cycles.
- States:
  - IDLE: no grant.
  - G0: gnt0=1, sel=0.
  - G1: gnt1=1, sel=1.
- Grants are one-hot; gnt0 & gnt1 is never 1.
- Latency: a req sampled at edge N produces its grant from edge N onward, visible in cycle N+1. Release works the same way.
- IDLE transitions:
  - req0 & req1: grant the requester != last.
  - req0 only: G0.
  - req1 only: G1.
  - No request: stay in IDLE; sel holds its previous value.
- Gk (k = current owner, o = other requester):
  - hold_cnt is 0 in the first granted cycle and increments each cycle in Gk.
  - reqk=0 and reqo=1: go directly to Go, no IDLE bubble, hold_cnt=0.
  - reqk=0 and reqo=0: go to IDLE.
  - reqk=1 and reqo=1 and hold_cnt==MAX_HOLD-1: preempt to Go, hold_cnt=0.
  - reqk=1 otherwise: stay in Gk. hold_cnt saturates at MAX_HOLD-1 when reqo=0.
- last is updated to k on every entry into Gk.
- MAX_HOLD=1 under continuous contention: grants alternate every cycle.
- Under continuous contention, each requester gets exactly MAX_HOLD consecutive cycles, then yields.
- A requester is never granted on the same edge its req is first seen low.
- hold_cnt is 8 bits wide.

Optional Feature:
- Macro: MUX_ARB_STATS_EN.
- Defined: adds outputs cnt0 and cnt1 (CW bits each).
  - cntk increments once on each entry into Gk; a continuous grant counts once.
  - Counters wrap modulo 2^CW.
  - Counters clear on Reset.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with req0=req1=1 held: during Reset, gnt0=gnt1=0 and y=0. First cycle after Reset: gnt0=1, sel=0, y=d0.
- Solo request: req1=1 for 3 cycles, then 0, with d1=1. gnt1=1 and sel=1 for 3 cycles starting 1 cycle after req1 rises; y=1; then IDLE, y=0, sel stays 1.
- Contention, MAX_HOLD=4, req0=req1=1 held for 16 cycles: grant pattern G0×4, G1×4, G0×4, G1×4; never both grants high.
- Handoff without bubble: in G0, req0 drops while req1=1. gnt1=1 on the very next cycle; busy stays 1.
- MAX_HOLD=1 with continuous contention: gnt0 and gnt1 alternate every cycle; with d0=0, d1=1, y toggles 0,1,0,1.
- MUX_ARB_STATS_EN with CW=2: 5 separate solo grants to requester 0 → cnt0=1 (wraps 3→0→1), cnt1=0. Reset asserted mid-grant → both counters 0 next cycle.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// mux2_rr_arbiter : round-robin owner arbitration for the shared 2:1 data mux.
// Optional grant statistics (cnt0_o/cnt1_o) when MUX_ARB_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4,
    parameter int CW       = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    output logic         gnt0_o,
    output logic         gnt1_o,
    output logic         sel_o,
    output logic [W-1:0] y_o,
    output logic         busy_o
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CW-1:0] cnt0_o,
    output logic [CW-1:0] cnt1_o
`endif
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_q,  hold_d;
    logic        last_q,  last_d;
    logic        sel_q,   sel_d;
    logic        enter_g0, enter_g1;

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || CW < 1 || W < 1) begin : g_param_check
        $error("mux2_rr_arbiter: illegal parameter value");
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'd0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        sel_d   = sel_q;

        case (state_q)
            ST_IDLE: begin
                hold_d = 8'd0;
                if (req0_i && req1_i) begin
                    // last_q names the previous owner; the other side wins the tie
                    state_d = last_q ? ST_G0 : ST_G1;
                end else if (req0_i) begin
                    state_d = ST_G0;
                end else if (req1_i) begin
                    state_d = ST_G1;
                end
            end
            ST_G0: begin
                if (!req0_i) begin
                    hold_d  = 8'd0;
                    state_d = req1_i ? ST_G1 : ST_IDLE;
                end else if (req1_i && (hold_q == HOLD_LAST)) begin
                    hold_d  = 8'd0;
                    state_d = ST_G1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_G1: begin
                if (!req1_i) begin
                    hold_d  = 8'd0;
                    state_d = req0_i ? ST_G0 : ST_IDLE;
                end else if (req0_i && (hold_q == HOLD_LAST)) begin
                    hold_d  = 8'd0;
                    state_d = ST_G0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 8'd0;
            end
        endcase

        enter_g0 = (state_d == ST_G0) && (state_q != ST_G0);
        enter_g1 = (state_d == ST_G1) && (state_q != ST_G1);

        if (enter_g0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (enter_g1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end
    end

    assign gnt0_o = (state_q == ST_G0);
    assign gnt1_o = (state_q == ST_G1);
    assign sel_o  = sel_q;
    assign busy_o = gnt0_o | gnt1_o;
    assign y_o    = gnt0_o ? d0_i : (gnt1_o ? d1_i : '0);

`ifdef MUX_ARB_STATS_EN
    logic [CW-1:0] cnt0_q, cnt1_q;

    // Counting entries rather than cycles: a continuous grant counts once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (enter_g0) cnt0_q <= cnt0_q + 1'b1;
            if (enter_g1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (MAX_HOLD=4 and MAX_HOLD=1 instances).
`default_nettype none

module tb_mux2_rr_arbiter;

    logic clk = 1'b0;
    logic rst, req0, req1;
    logic [0:0] d0, d1;

    logic g0_a, g1_a, sel_a, busy_a;
    logic [0:0] y_a;
    logic g0_b, g1_b, sel_b, busy_b;
    logic [0:0] y_b;
`ifdef MUX_ARB_STATS_EN
    logic [1:0] c0_a, c1_a;
    logic [7:0] c0_b, c1_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.W(1), .MAX_HOLD(4), .CW(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .d0_i(d0), .d1_i(d1), .gnt0_o(g0_a), .gnt1_o(g1_a),
        .sel_o(sel_a), .y_o(y_a), .busy_o(busy_a)
`ifdef MUX_ARB_STATS_EN
        , .cnt0_o(c0_a), .cnt1_o(c1_a)
`endif
    );

    mux2_rr_arbiter #(.W(1), .MAX_HOLD(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .d0_i(d0), .d1_i(d1), .gnt0_o(g0_b), .gnt1_o(g1_b),
        .sel_o(sel_b), .y_o(y_b), .busy_o(busy_b)
`ifdef MUX_ARB_STATS_EN
        , .cnt0_o(c0_b), .cnt1_o(c1_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic eg1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = 1'b0; d1 = 1'b1;
        tick();
        chk("rst_gnt0", {7'd0, g0_a}, 8'd0);
        chk("rst_gnt1", {7'd0, g1_a}, 8'd0);
        chk("rst_y",    {7'd0, y_a},  8'd0);
        chk("rst_sel",  {7'd0, sel_a}, 8'd0);
        chk("rst_busy", {7'd0, busy_a}, 8'd0);
        chk("rst_b_gnt", {6'd0, g0_b, g1_b}, 8'd0);

        // Continuous contention: A expects blocks of 4, B alternates every cycle.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            eg1 = ((i / 4) % 2) == 1;
            chk($sformatf("cont_a_gnt0_%0d", i), {7'd0, g0_a}, {7'd0, ~eg1});
            chk($sformatf("cont_a_gnt1_%0d", i), {7'd0, g1_a}, {7'd0, eg1});
            chk($sformatf("cont_a_y_%0d", i), {7'd0, y_a}, {7'd0, eg1});
            chk($sformatf("cont_a_onehot_%0d", i), {7'd0, g0_a & g1_a}, 8'd0);
            chk($sformatf("cont_b_gnt1_%0d", i), {7'd0, g1_b}, {7'd0, (i % 2) == 1});
            chk($sformatf("cont_b_gnt0_%0d", i), {7'd0, g0_b}, {7'd0, (i % 2) == 0});
            chk($sformatf("cont_b_y_%0d", i), {7'd0, y_b}, {7'd0, (i % 2) == 1});
        end

        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("idle_busy", {7'd0, busy_a}, 8'd0);
        chk("idle_y",    {7'd0, y_a},    8'd0);
        chk("idle_sel",  {7'd0, sel_a},  8'd1);

        // Solo requester 1 for three sampled edges.
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("solo1_gnt1_%0d", i), {7'd0, g1_a}, 8'd1);
            chk($sformatf("solo1_sel_%0d", i),  {7'd0, sel_a}, 8'd1);
            chk($sformatf("solo1_y_%0d", i),    {7'd0, y_a},   8'd1);
        end
        req1 = 1'b0;
        tick();
        chk("solo1_rel_gnt1", {7'd0, g1_a}, 8'd0);
        chk("solo1_rel_y",    {7'd0, y_a},  8'd0);
        chk("solo1_rel_sel",  {7'd0, sel_a}, 8'd1);

        // Handoff without an IDLE bubble.
        req0 = 1'b1;
        tick();
        chk("hand_gnt0", {7'd0, g0_a}, 8'd1);
        chk("hand_sel0", {7'd0, sel_a}, 8'd0);
        req0 = 1'b0; req1 = 1'b1;
        tick();
        chk("hand_gnt1", {7'd0, g1_a}, 8'd1);
        chk("hand_gnt0_off", {7'd0, g0_a}, 8'd0);
        chk("hand_busy", {7'd0, busy_a}, 8'd1);

        // Saturated hold count: a late competitor preempts on its first edge.
        for (int i = 0; i < 5; i++) tick();
        chk("sat_still_gnt1", {7'd0, g1_a}, 8'd1);
        req0 = 1'b1;
        tick();
        chk("sat_preempt_gnt0", {7'd0, g0_a}, 8'd1);
        chk("sat_preempt_gnt1", {7'd0, g1_a}, 8'd0);

        // Reset in the middle of a grant.
        req1 = 1'b0;
        tick();
        chk("mid_pre_gnt0", {7'd0, g0_a}, 8'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt0", {7'd0, g0_a}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy_a}, 8'd0);
        rst = 1'b0; req0 = 1'b0;
        tick();

`ifdef MUX_ARB_STATS_EN
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1;
            tick();
            req0 = 1'b0;
            tick();
        end
        chk("stats_cnt0_wrap", {6'd0, c0_a}, 8'd1);
        chk("stats_cnt1", {6'd0, c1_a}, 8'd0);
        req0 = 1'b1;
        tick();
        chk("stats_cnt0_pre", {6'd0, c0_a}, 8'd2);
        rst = 1'b1;
        tick();
        chk("stats_rst_cnt0", {6'd0, c0_a}, 8'd0);
        chk("stats_rst_cnt1", {6'd0, c1_a}, 8'd0);
        rst = 1'b0; req0 = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
